// File: rtl/blink_multi.sv
// Multi-channel LED blinker: a shared prescaler tick drives per-channel
// OFF/ON/BLINK/ONESHOT engines, programmed through a write-only config port.
module blink_multi #(
  parameter int NCH   = 4,
  parameter int CBITS = 30,
  parameter int PBITS = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_valid,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                            cfg_mode,
  input  logic [CBITS-1:0]                      cfg_half,
  output logic                                  cfg_err,
  output logic [NCH-1:0]                        led,
  output logic [NCH-1:0]                        flg,
  output logic [NCH-1:0]                        active
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW:0] NCH_V = (CHW + 1)'(NCH);

  typedef enum logic [1:0] {
    M_OFF     = 2'd0,
    M_ON      = 2'd1,
    M_BLINK   = 2'd2,
    M_ONESHOT = 2'd3
  } mode_t;

  mode_t            mode [NCH];
  logic [CBITS-1:0] half [NCH];
  logic [CBITS-1:0] cnt  [NCH];

  logic           tick;
  logic           ch_ok;
  logic [NCH-1:0] wr_sel;

  // PBITS=0 has no prescaler register at all: every cycle is a tick.
  generate
    if (PBITS == 0) begin : g_nopre
      assign tick = 1'b1;
    end else begin : g_pre
      logic [PBITS-1:0] pre;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) pre <= '0;
        else      pre <= pre + PBITS'(1);
      end
      assign tick = &pre;
    end
  endgenerate

  assign ch_ok  = ({1'b0, cfg_ch} < NCH_V);
  assign wr_sel = (cfg_valid && ch_ok) ? (NCH'(1) << cfg_ch) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_err <= 1'b0;
      led     <= '0;
      flg     <= '0;
      for (int i = 0; i < NCH; i++) begin
        mode[i] <= M_OFF;
        half[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      cfg_err <= cfg_valid && !ch_ok;
      for (int i = 0; i < NCH; i++) begin
        flg[i] <= 1'b0;
        // A write to this channel takes priority over a coincident tick.
        if (wr_sel[i]) begin
          mode[i] <= mode_t'(cfg_mode);
          half[i] <= cfg_half;
          cnt[i]  <= cfg_half;
          led[i]  <= (cfg_mode != 2'd0);
        end else if (tick) begin
          case (mode[i])
            M_BLINK: begin
              if (cnt[i] == '0) begin
                cnt[i] <= half[i];
                led[i] <= ~led[i];
                flg[i] <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] - CBITS'(1);
              end
            end
            M_ONESHOT: begin
              if (cnt[i] == '0) begin
                led[i]  <= 1'b0;
                flg[i]  <= 1'b1;
                mode[i] <= M_OFF;
              end else begin
                cnt[i] <= cnt[i] - CBITS'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < NCH; i++) active[i] = (mode[i] != M_OFF);
  end

endmodule

// File: tb/tb_blink_multi.sv
// Randomised bench for blink_multi: a 4-channel and a 3-channel instance share
// stimulus and are checked every cycle against a tick-arithmetic reference model.
module tb_blink_multi;

  localparam int CBITS = 8;
  localparam int PBITS = 2;
  localparam int PMOD  = 1 << PBITS;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_half;

  logic       err_a, err_b;
  logic [3:0] led_a, flg_a, active_a;
  logic [2:0] led_b, flg_b, active_b;

  int checks   = 0;
  int failures = 0;

  // Reference state: [dut][channel]; dut 0 has 4 channels, dut 1 has 3.
  int   m_mode  [2][4];
  int   m_half  [2][4];
  int   m_start [2][4];
  logic m_led   [2][4];
  logic m_flg   [2][4];
  logic m_err   [2];
  int   pre_m;
  int   tick_count;

  blink_multi #(.NCH(4), .CBITS(CBITS), .PBITS(PBITS)) dut_a (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_err(err_a),
    .led(led_a), .flg(flg_a), .active(active_a)
  );

  blink_multi #(.NCH(3), .CBITS(CBITS), .PBITS(PBITS)) dut_b (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_err(err_b),
    .led(led_b), .flg(flg_b), .active(active_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    pre_m      = 0;
    tick_count = 0;
    for (int d = 0; d < 2; d++) begin
      m_err[d] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_mode[d][c]  = 0;
        m_half[d][c]  = 0;
        m_start[d][c] = 0;
        m_led[d][c]   = 1'b0;
        m_flg[d][c]   = 1'b0;
      end
    end
  endtask

  // Led state is derived from how many ticks elapsed since the channel was written.
  task automatic modelEdge(input int v, input int ch, input int md, input int hf);
    bit tick;
    int n, p, nch;
    tick  = (pre_m == PMOD - 1);
    pre_m = (pre_m + 1) % PMOD;
    if (tick) tick_count++;
    for (int d = 0; d < 2; d++) begin
      nch      = (d == 0) ? 4 : 3;
      m_err[d] = (v != 0) && (ch >= nch);
      for (int c = 0; c < nch; c++) begin
        m_flg[d][c] = 1'b0;
        if (v != 0 && ch == c) begin
          m_mode[d][c]  = md;
          m_half[d][c]  = hf;
          m_start[d][c] = tick_count;
          m_led[d][c]   = (md != 0);
        end else if (tick) begin
          n = tick_count - m_start[d][c];
          p = m_half[d][c] + 1;
          if (m_mode[d][c] == 2 && (n % p) == 0) begin
            m_flg[d][c] = 1'b1;
            m_led[d][c] = ((n / p) % 2) == 0;
          end else if (m_mode[d][c] == 3 && n == p) begin
            m_flg[d][c]  = 1'b1;
            m_led[d][c]  = 1'b0;
            m_mode[d][c] = 0;
          end
        end
      end
    end
  endtask

  task automatic compareAll(input string tag);
    logic [3:0] el, ef, ea;
    for (int d = 0; d < 2; d++) begin
      el = '0; ef = '0; ea = '0;
      for (int c = 0; c < ((d == 0) ? 4 : 3); c++) begin
        el[c] = m_led[d][c];
        ef[c] = m_flg[d][c];
        ea[c] = (m_mode[d][c] != 0);
      end
      if (d == 0) begin
        checkOutput({tag, ".led_a"},    32'(led_a),    32'(el));
        checkOutput({tag, ".flg_a"},    32'(flg_a),    32'(ef));
        checkOutput({tag, ".active_a"}, 32'(active_a), 32'(ea));
        checkOutput({tag, ".err_a"},    32'(err_a),    32'(m_err[0]));
      end else begin
        checkOutput({tag, ".led_b"},    32'(led_b),    32'(el));
        checkOutput({tag, ".flg_b"},    32'(flg_b),    32'(ef));
        checkOutput({tag, ".active_b"}, 32'(active_b), 32'(ea));
        checkOutput({tag, ".err_b"},    32'(err_b),    32'(m_err[1]));
      end
    end
  endtask

  // Called at a falling edge: drive inputs, advance the model one edge, check.
  task automatic applyStimulus(input int v, input int ch, input int md, input int hf, input string tag);
    cfg_valid = (v != 0);
    cfg_ch    = 2'(ch);
    cfg_mode  = 2'(md);
    cfg_half  = 8'(hf);
    modelEdge(v, ch, md, hf);
    @(negedge clk);
    compareAll(tag);
  endtask

  task automatic idle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) applyStimulus(0, 0, 0, 0, tag);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic midReset();
    #3;
    rst = 1'b0;
    #1;
    modelReset();
    compareAll("async_reset");
    @(negedge clk);
    rst = 1'b1;
    compareAll("reset_release");
  endtask

  initial begin
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = '0;
    cfg_half  = '0;
    modelReset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    compareAll("reset");

    idle(3, "idle");
    applyStimulus(1, 1, 2, 2, "blink_wr");
    idle(30, "blink");
    applyStimulus(1, 2, 3, 1, "oneshot_wr");
    idle(12, "oneshot");

    while (pre_m != PMOD - 1) applyStimulus(0, 0, 0, 0, "align");
    applyStimulus(1, 0, 2, 0, "collide_wr");
    idle(10, "collide");

    applyStimulus(1, 3, 0, 0, "invalid_wr");
    idle(3, "invalid");

    applyStimulus(1, 3, 2, 5, "ovr_blink");
    idle(9, "ovr_mid");
    applyStimulus(1, 3, 1, 0, "ovr_on");
    idle(10, "ovr_steady");
    applyStimulus(1, 3, 0, 0, "ovr_off");
    idle(3, "ovr_done");

    applyStimulus(1, 0, 0, 0, "pat0");
    applyStimulus(1, 1, 1, 0, "pat1");
    applyStimulus(1, 2, 0, 0, "pat2");
    applyStimulus(1, 3, 1, 0, "pat3");
    checkOutput("pattern_1010", 32'(led_a), 32'h0000_000a);
    midReset();

    applyStimulus(1, 0, 2, 0, "first_tick_wr");
    idle(6, "first_tick");

    for (int i = 0; i < 3000; i++) begin
      int v, ch, md, hf;
      v  = (($urandom % 6) == 0) ? 1 : 0;
      ch = $urandom % 4;
      md = $urandom % 4;
      hf = (($urandom % 8) == 0) ? ($urandom % 64) : ($urandom % 4);
      applyStimulus(v, ch, md, hf, "rand");
      if (i == 1500) midReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
